counter_step_sequencer: RTL and testbench
=========================================

Name: counter_step_sequencer

Overview:
- Controller that sequences the up/down counter datapath from the single board clock, replacing the derived divided-clock scheme.
- Generates one-cycle step strobes (cnt_en, cnt_up) and a clear strobe (cnt_clr) on a programmable tick.
- Tracks a shadow copy of the counter value so it can apply wrap or bounce (reverse at limits) policy.
- Sits between front-panel controls (start/stop/clear/direction switch) and the counter datapath.

Parameters:
DIV, 25000000, tick period in clock cycles (>=2)
DIV_W, 25, prescaler width; must satisfy 2^DIV_W > DIV-1
W, 3, counter/shadow value width

Ports:
c  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
start  input  1  level; request RUN
stop  input  1  level; request PAUSE
clr  input  1  level; request clear
s  input  1  direction switch, 1=up, 0=down
bounce  input  1  1=reverse at limits, 0=wrap modulo 2^W
cnt_en  output  1  one-cycle step strobe to datapath
cnt_up  output  1  step direction, valid when cnt_en=1
cnt_clr  output  1  one-cycle clear strobe to datapath
value  output  W  shadow counter value
state  output  2  current FSM state code
tick  output  1  one-cycle prescaler tick (debug)

Behaviour:
- Interface: one clock c; reset is synchronous and active-high, named reset. All outputs registered.
- Reset values: state=IDLE, value=0, dir=1, div_cnt=0; cnt_en, cnt_clr and tick=0; cnt_up=1.
- States: IDLE=00, RUN=01, PAUSE=10, CLEAR=11.
- Prescaler:
  - div_cnt counts 0..DIV-1 only in RUN; held at 0 in all other states.
  - tick=1 for the cycle after div_cnt==DIV-1, then div_cnt returns to 0.
  - First step occurs DIV cycles after entering RUN.
- Priority each cycle: clr > stop > start > tick.
- IDLE:
  - value held at 0.
  - start=1 and stop=0 -> RUN; dir<=s on the same edge.
  - start and stop both high -> remain IDLE.
- RUN, on tick and no higher-priority request:
  - cnt_en=1 for exactly one cycle and value updates on the same edge.
  - bounce=0: dir<=s at each tick; value steps by ±1 using the new dir; wraps modulo 2^W (max->0 up, 0->max down).
  - bounce=1: s ignored after start. If value==2^W-1 with dir=1, or value==0 with dir=0, flip dir and step in the new direction (7 up -> 6, dir=0). Otherwise step by ±1.
  - cnt_up = direction used for that step.
- RUN + stop -> PAUSE. No step that cycle even if tick is due; prescaler clears.
- PAUSE:
  - value and dir held.
  - start (stop=0) -> RUN, prescaler restarts from 0, dir unchanged (also in wrap mode until next tick).
- clr in any state -> CLEAR. Next cycle: cnt_clr=1 for one cycle, value=0, then unconditionally IDLE. dir is not reset.
- clr held high: FSM re-enters CLEAR every other cycle (CLEAR->IDLE->CLEAR); cnt_clr pulses accordingly.
- reset overrides everything, including mid-CLEAR and mid-prescale.
- cnt_en and cnt_clr are never high in the same cycle.

Test Plan:
- DIV=4, W=3, reset then start=1, s=1, bounce=0 -> first cnt_en 4 cycles after RUN entry; value 1,2,...,7,0 every 4 cycles; cnt_up=1 on each strobe.
- DIV=4, bounce=1, s=1, start, run 10 ticks -> value 1..7 then 6,5,4; cnt_up=0 from the 8th strobe onward.
- DIV=4, bounce=0, running up at value=3, set s=0 -> next tick value=2, cnt_up=0; value=0 then next tick value=7.
- stop asserted on the exact cycle tick is due -> no cnt_en, state=PAUSE (10), value unchanged. Re-start -> next step exactly 4 cycles later.
- clr with start and stop also high, in RUN -> state 11 for one cycle, cnt_clr=1 for one cycle, value=0, then state=00; no cnt_en.
- reset asserted mid-prescale with value=5 -> next edge value=0, state=00, all strobes 0, cnt_up=1.

Source files
------------

// File: rtl/counter_step_sequencer.sv
// Step/clear sequencer for the up/down counter datapath, driven by a single clock
// with a programmable prescaler tick and a shadow counter for wrap/bounce policy.
module counter_step_sequencer #(
    parameter int DIV   = 25000000,
    parameter int DIV_W = 25,
    parameter int W     = 3
) (
    input  logic         c,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clr,
    input  logic         s,
    input  logic         bounce,
    output logic         cnt_en,
    output logic         cnt_up,
    output logic         cnt_clr,
    output logic [W-1:0] value,
    output logic [1:0]   state,
    output logic         tick
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [W-1:0]     VAL_MAX  = '1;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [W-1:0]       value_q, value_d;
    logic               dir_q, dir_d;
    logic               cnt_en_q, cnt_en_d;
    logic               cnt_up_q, cnt_up_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               tick_q, tick_d;
    logic               step_dir;
    logic               tick_due;

    always_comb begin
        state_d   = state_q;
        div_cnt_d = '0;
        value_d   = value_q;
        dir_d     = dir_q;
        cnt_en_d  = 1'b0;
        cnt_up_d  = cnt_up_q;
        cnt_clr_d = 1'b0;
        tick_d    = 1'b0;
        step_dir  = dir_q;
        tick_due  = (div_cnt_q == DIV_LAST);

        // CLEAR always falls back to IDLE, so a held clr pulses every other cycle.
        if (clr && state_q != ST_CLEAR) begin
            state_d   = ST_CLEAR;
            cnt_clr_d = 1'b1;
            value_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    value_d = '0;
                    if (start && !stop) begin
                        state_d = ST_RUN;
                        dir_d   = s;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (tick_due) begin
                        if (!bounce) begin
                            step_dir = s;
                        end else if ((dir_q && value_q == VAL_MAX) || (!dir_q && value_q == '0)) begin
                            step_dir = !dir_q;
                        end else begin
                            step_dir = dir_q;
                        end
                        dir_d    = step_dir;
                        value_d  = step_dir ? value_q + W'(1) : value_q - W'(1);
                        cnt_en_d = 1'b1;
                        cnt_up_d = step_dir;
                        tick_d   = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    value_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge c) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            value_q   <= '0;
            dir_q     <= 1'b1;
            cnt_en_q  <= 1'b0;
            cnt_up_q  <= 1'b1;
            cnt_clr_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            value_q   <= value_d;
            dir_q     <= dir_d;
            cnt_en_q  <= cnt_en_d;
            cnt_up_q  <= cnt_up_d;
            cnt_clr_q <= cnt_clr_d;
            tick_q    <= tick_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign cnt_up  = cnt_up_q;
    assign cnt_clr = cnt_clr_q;
    assign value   = value_q;
    assign state   = state_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_counter_step_sequencer.sv
// Self-checking bench for counter_step_sequencer: directed scenarios with constant
// expectations, then randomized traffic against a cycle-count reference model.
module tb_counter_step_sequencer;

    localparam int DIV  = 4;
    localparam int W    = 3;
    localparam int VMAX = 7;

    logic         c = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         clr = 1'b0;
    logic         s = 1'b0;
    logic         bounce = 1'b0;
    logic         cnt_en;
    logic         cnt_up;
    logic         cnt_clr;
    logic [W-1:0] value;
    logic [1:0]   state;
    logic         tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position counted in plain integers, steps every DIV RUN cycles.
    int m_state   = 0;
    int m_value   = 0;
    int m_elapsed = 0;
    bit m_dir = 1'b1;
    bit m_en  = 1'b0;
    bit m_up  = 1'b1;
    bit m_clr = 1'b0;
    bit m_tick = 1'b0;

    counter_step_sequencer #(.DIV(DIV), .DIV_W(3), .W(W)) dut (
        .c(c), .reset(reset), .start(start), .stop(stop), .clr(clr), .s(s),
        .bounce(bounce), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr),
        .value(value), .state(state), .tick(tick)
    );

    always #5 c = ~c;

    task automatic model_update();
        m_en = 1'b0; m_clr = 1'b0; m_tick = 1'b0;
        if (reset) begin
            m_state = 0; m_value = 0; m_dir = 1'b1; m_up = 1'b1; m_elapsed = 0;
            return;
        end
        if (m_state == 3) begin
            m_state = 0;
            return;
        end
        if (clr) begin
            m_state = 3; m_clr = 1'b1; m_value = 0; m_elapsed = 0;
            return;
        end
        case (m_state)
            0: if (start && !stop) begin m_state = 1; m_dir = s; m_elapsed = 0; end
            1: begin
                if (stop) begin
                    m_state = 2; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed % DIV == 0) begin
                        if (!bounce) m_dir = s;
                        else if ((m_dir && m_value == VMAX) || (!m_dir && m_value == 0)) m_dir = !m_dir;
                        m_value = (m_value + (m_dir ? 1 : VMAX)) % (VMAX + 1);
                        m_en = 1'b1; m_up = m_dir; m_tick = 1'b1;
                    end
                end
            end
            2: if (start && !stop) begin m_state = 1; m_elapsed = 0; end
            default: m_state = 0;
        endcase
    endtask

    task automatic cycle();
        model_update();
        @(posedge c);
        #1;
    endtask

    task automatic wait_step(output int n, output bit ok);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            cycle();
            n++;
            if (cnt_en) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; clr = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        n_checks++;
        if ({state, value, cnt_en, cnt_clr, tick, cnt_up} !== {2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got st=%b val=%0d en=%b clr=%b tick=%b up=%b, required st=00 val=0 en=0 clr=0 tick=0 up=1",
                     state, value, cnt_en, cnt_clr, tick, cnt_up);
        end
        $display("test_reset: state=%b value=%0d", state, value);
    endtask

    task automatic test_wrap_up();
        int n; bit ok;
        s = 1'b1; bounce = 1'b0; start = 1'b1;
        cycle();
        n_checks++;
        if (state !== 2'b01) begin n_fail++; $display("FAIL wrap_up_enter_run: got state=%b required 01", state); end
        for (int k = 1; k <= 8; k++) begin
            wait_step(n, ok);
            n_checks++;
            if (!ok || n != DIV) begin n_fail++; $display("FAIL wrap_up_latency step %0d: got %0d cycles (seen=%0b) required %0d", k, n, ok, DIV); end
            n_checks++;
            if (value !== 3'(k % 8) || cnt_up !== 1'b1 || tick !== 1'b1 || cnt_clr !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_up_step %0d: got val=%0d up=%b tick=%b clr=%b required val=%0d up=1 tick=1 clr=0", k, value, cnt_up, tick, cnt_clr, k % 8);
            end
            $display("wrap_up step %0d: value=%0d up=%b after %0d cycles", k, value, cnt_up, n);
        end
    endtask

    task automatic test_wrap_down();
        int n; bit ok;
        int exp_v[4] = '{2, 1, 0, 7};
        for (int k = 0; k < 3; k++) wait_step(n, ok);
        n_checks++;
        if (value !== 3'd3) begin n_fail++; $display("FAIL wrap_down_setup: got val=%0d required 3", value); end
        s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_step(n, ok);
            n_checks++;
            if (!ok || value !== 3'(exp_v[k]) || cnt_up !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_down_step %0d: got val=%0d up=%b seen=%0b required val=%0d up=0", k, value, cnt_up, ok, exp_v[k]);
            end
            $display("wrap_down step %0d: value=%0d up=%b", k, value, cnt_up);
        end
    endtask

    task automatic test_stop_on_tick();
        int n; bit ok;
        logic [W-1:0] v;
        v = value;
        for (int k = 0; k < DIV - 1; k++) cycle();
        stop = 1'b1; start = 1'b0;
        cycle();
        n_checks++;
        if (state !== 2'b10 || cnt_en !== 1'b0 || tick !== 1'b0 || value !== v) begin
            n_fail++;
            $display("FAIL stop_on_tick: got st=%b en=%b tick=%b val=%0d required st=10 en=0 tick=0 val=%0d", state, cnt_en, tick, value, v);
        end
        cycle(); cycle();
        n_checks++;
        if (state !== 2'b10 || value !== v) begin n_fail++; $display("FAIL pause_hold: got st=%b val=%0d required st=10 val=%0d", state, value, v); end
        stop = 1'b0; start = 1'b1;
        cycle();
        n_checks++;
        if (state !== 2'b01) begin n_fail++; $display("FAIL restart_run: got state=%b required 01", state); end
        wait_step(n, ok);
        n_checks++;
        if (!ok || n != DIV || value !== v - 3'd1 || cnt_up !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_step: got %0d cycles val=%0d up=%b seen=%0b required %0d cycles val=%0d up=0", n, value, cnt_up, ok, DIV, v - 3'd1);
        end
        $display("stop/restart: value=%0d after %0d cycles", value, n);
    endtask

    task automatic test_clr_all();
        cycle(); cycle();
        clr = 1'b1; start = 1'b1; stop = 1'b1;
        cycle();
        n_checks++;
        if (state !== 2'b11 || cnt_clr !== 1'b1 || value !== 3'd0 || cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_enter: got st=%b clr=%b val=%0d en=%b required st=11 clr=1 val=0 en=0", state, cnt_clr, value, cnt_en);
        end
        clr = 1'b0; start = 1'b0; stop = 1'b0;
        cycle();
        n_checks++;
        if (state !== 2'b00 || cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clr_exit: got st=%b clr=%b required st=00 clr=0", state, cnt_clr); end
        clr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (state !== ((k % 2 == 0) ? 2'b11 : 2'b00) || cnt_clr !== (k % 2 == 0)) begin
                n_fail++;
                $display("FAIL clr_held cycle %0d: got st=%b clr=%b required st=%b clr=%0d", k, state, cnt_clr, (k % 2 == 0) ? 2'b11 : 2'b00, (k % 2 == 0));
            end
        end
        clr = 1'b0;
        cycle();
        $display("clr: state=%b value=%0d", state, value);
    endtask

    task automatic test_bounce();
        int n; bit ok;
        int exp_v[10] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4};
        bounce = 1'b1; s = 1'b1; start = 1'b1;
        cycle();
        for (int k = 0; k < 10; k++) begin
            s = 1'($urandom_range(0, 1));
            wait_step(n, ok);
            n_checks++;
            if (!ok || value !== 3'(exp_v[k]) || cnt_up !== (k < 7)) begin
                n_fail++;
                $display("FAIL bounce_step %0d: got val=%0d up=%b seen=%0b required val=%0d up=%0d", k, value, cnt_up, ok, exp_v[k], (k < 7));
            end
            $display("bounce step %0d: value=%0d up=%b", k, value, cnt_up);
        end
    endtask

    task automatic test_reset_mid();
        int n; bit ok;
        clr = 1'b1; cycle(); clr = 1'b0; cycle();
        bounce = 1'b0; s = 1'b1; start = 1'b1;
        cycle();
        for (int k = 0; k < 5; k++) wait_step(n, ok);
        cycle(); cycle();
        n_checks++;
        if (value !== 3'd5) begin n_fail++; $display("FAIL reset_mid_setup: got val=%0d required 5", value); end
        reset = 1'b1; start = 1'b0;
        cycle();
        reset = 1'b0;
        n_checks++;
        if ({state, value, cnt_en, cnt_clr, tick, cnt_up} !== {2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid: got st=%b val=%0d en=%b clr=%b tick=%b up=%b required st=00 val=0 en=0 clr=0 tick=0 up=1",
                     state, value, cnt_en, cnt_clr, tick, cnt_up);
        end
        start = 1'b1; stop = 1'b1;
        cycle();
        n_checks++;
        if (state !== 2'b00) begin n_fail++; $display("FAIL idle_start_stop: got state=%b required 00", state); end
        start = 1'b0; stop = 1'b0;
        $display("reset mid-prescale: state=%b value=%0d", state, value);
    endtask

    task automatic test_random();
        logic [8:0] got, want;
        int steps = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 0) bounce = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 299) == 0);
            clr   = ($urandom_range(0, 59) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            start = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) s = ~s;
            cycle();
            got  = {state, value, cnt_en, cnt_up, cnt_clr, tick};
            want = {2'(m_state), 3'(m_value), m_en, m_up, m_clr, m_tick};
            if (m_en) steps++;
            n_checks++;
            if (got !== want || (cnt_en && cnt_clr)) begin
                n_fail++;
                $display("FAIL random cycle %0d: got st=%b val=%0d en=%b up=%b clr=%b tick=%b required st=%b val=%0d en=%b up=%b clr=%b tick=%b",
                         i, state, value, cnt_en, cnt_up, cnt_clr, tick, want[8:7], want[6:4], m_en, m_up, m_clr, m_tick);
            end
        end
        reset = 1'b0; clr = 1'b0; stop = 1'b0; start = 1'b0;
        $display("random: 4000 cycles, %0d steps", steps);
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_stop_on_tick();
        test_clr_all();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
